// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer arbitrating the single data_memory port
//
// Purpose: queue stores from the memory stage and write them to data_memory
// one per cycle whenever no load is using the port. A load is stalled while
// any pending store overlaps its bytes, or when a store arrives in the same
// cycle.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_size, st_ready   store request and acceptance
//   ld_valid/ld_addr/ld_size, ld_stall           load request and stall
//   addr_mem/wdata_mem/rd_wr_mem/mem_wr          data_memory port
//   sb_empty, sb_count                           occupancy status
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_size,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_size,
  output logic             ld_stall,
  output logic [31:0]      addr_mem,
  output logic [31:0]      wdata_mem,
  output logic [2:0]       rd_wr_mem,
  output logic             mem_wr,
  output logic             sb_empty,
  output logic [CNT_W-1:0] sb_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] LB_SB = 3'b000;
  localparam logic [2:0] LH_SH = 3'b001;
  localparam logic [2:0] LW_SW = 3'b010;
  localparam logic [2:0] LHU   = 3'b101;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [2:0]       size_q [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             hazard;
  logic             enq;
  logic             drain;
  logic [PTR_W-1:0] offset;
  logic [32:0]      ld_end;

  // Last byte address of an access, in 33 bits so a range never wraps past
  // the top of the address space. Unknown size codes behave as one byte.
  function automatic logic [32:0] span_end(input logic [31:0] a, input logic [2:0] s);
    logic [32:0] len;
    case (s)
      LH_SH, LHU: len = 33'd2;
      LW_SW:      len = 33'd4;
      default:    len = 33'd1;
    endcase
    return {1'b0, a} + len - 33'd1;
  endfunction

  // An entry is live when its distance from head is below count.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    ld_end = span_end(ld_addr, ld_size);
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head;
      if ((CNT_W'(offset) < count) &&
          ({1'b0, addr_q[i]} <= ld_end) &&
          ({1'b0, ld_addr} <= span_end(addr_q[i], size_q[i])))
        hazard = 1'b1;
    end
  end

  assign st_ready = !reset && (count < CNT_W'(DEPTH));
  assign ld_stall = !reset && ld_valid && (hazard || st_valid);
  assign enq      = st_valid && st_ready;
  assign sb_empty = (count == '0);
  assign sb_count = count;

  // Port priority: unstalled load, then drain of head, else idle.
  always_comb begin
    addr_mem  = '0;
    wdata_mem = '0;
    rd_wr_mem = LB_SB;
    mem_wr    = 1'b0;
    drain     = 1'b0;
    if (!reset) begin
      if (ld_valid && !ld_stall) begin
        addr_mem  = ld_addr;
        rd_wr_mem = ld_size;
      end else if (count != '0) begin
        addr_mem  = addr_q[head];
        wdata_mem = data_q[head];
        rd_wr_mem = size_q[head];
        mem_wr    = 1'b1;
        drain     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        addr_q[tail] <= st_addr;
        data_q[tail] <= st_data;
        size_q[tail] <= st_size;
        tail         <= tail + PTR_W'(1);
      end
      if (drain)
        head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end

endmodule
